// File: rtl/multi_cycle_sequencer.sv
// multi_cycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control for the 16-bit datapath.
// Optional macro SEQ_HALT_EN: undefined opcodes stop the sequencer in HALT.
module multi_cycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      IR,
    input  logic [3:0]       flags,
    input  logic             memAck,
    output logic             irLoad,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             addrSel,
    output logic             pcWrite,
    output logic [1:0]       choosePCUpdate,
    output logic [1:0]       funSel,
    output logic             chooseOperand2,
    output logic             flagsLoad,
    output logic             regWrite,
    output logic             ldRA,
    output logic             chooseWriteBack,
    output logic [2:0]       rChooseOne,
    output logic [2:0]       rChooseTwo,
    output logic [2:0]       writeChoose,
    output logic [CNT_W-1:0] instrCount,
    output logic             halted
);

    localparam logic [4:0] OP_LI   = 5'b00000;
    localparam logic [4:0] OP_LR   = 5'b00001;
    localparam logic [4:0] OP_STR  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_SUBI = 5'b01001;
    localparam logic [4:0] OP_MNSI = 5'b01010;
    localparam logic [4:0] OP_ADDR = 5'b01100;
    localparam logic [4:0] OP_SUBR = 5'b01101;
    localparam logic [4:0] OP_MNSR = 5'b01110;
    localparam logic [4:0] OP_CMP  = 5'b01111;
    localparam logic [4:0] OP_J    = 5'b11111;
    localparam logic [4:0] OP_JNM  = 5'b10000;
    localparam logic [4:0] OP_JZ   = 5'b10001;
    localparam logic [4:0] OP_JNZ  = 5'b10010;
    localparam logic [4:0] OP_JC   = 5'b10011;
    localparam logic [4:0] OP_JNC  = 5'b10100;
    localparam logic [4:0] OP_JV   = 5'b10101;
    localparam logic [4:0] OP_JNV  = 5'b10110;
    localparam logic [4:0] OP_JM   = 5'b10111;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JR   = 5'b11101;

`ifdef SEQ_HALT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;
`endif

    state_t           r_state;
    logic [15:0]      r_irq;
    logic [CNT_W-1:0] r_cnt;

    logic [4:0] w_op;
    logic       w_alu;
    logic       w_regop;
    logic       w_same2;
    logic       w_lr;
    logic       w_str;
    logic       w_flg;
    logic       w_op2;
    logic       w_towb;
    logic       w_jal;
    logic       w_stop;
    logic [1:0] w_fun;
    logic [1:0] w_pcsel;
    logic       w_unused;

    assign w_op       = r_irq[15:11];
    assign w_unused   = ^r_irq[4:0];
    assign instrCount = r_cnt;

    // Classify the held instruction and resolve the PC source
    always_comb begin
        w_alu   = 1'b0;
        w_regop = 1'b0;
        w_same2 = 1'b0;
        w_lr    = 1'b0;
        w_str   = 1'b0;
        w_flg   = 1'b0;
        w_op2   = 1'b0;
        w_towb  = 1'b0;
        w_jal   = 1'b0;
        w_stop  = 1'b0;
        w_fun   = 2'd0;
        w_pcsel = 2'd2;
        unique case (w_op)
            OP_LI:   begin w_alu = 1'b1; w_fun = 2'd2; w_towb = 1'b1; end
            OP_LR:   begin w_lr = 1'b1; w_same2 = 1'b1; end
            OP_STR:  begin w_str = 1'b1; w_regop = 1'b1; end
            OP_ADDI: begin w_alu = 1'b1; w_flg = 1'b1; w_towb = 1'b1; end
            OP_SUBI: begin
                w_alu = 1'b1; w_fun = 2'd1; w_flg = 1'b1; w_towb = 1'b1;
            end
            OP_MNSI: begin w_alu = 1'b1; w_fun = 2'd1; w_flg = 1'b1; end
            OP_ADDR: begin
                w_alu = 1'b1; w_regop = 1'b1; w_op2 = 1'b1;
                w_flg = 1'b1; w_towb = 1'b1;
            end
            OP_SUBR: begin
                w_alu = 1'b1; w_regop = 1'b1; w_op2 = 1'b1;
                w_fun = 2'd1; w_flg = 1'b1; w_towb = 1'b1;
            end
            OP_MNSR: begin
                w_alu = 1'b1; w_regop = 1'b1; w_op2 = 1'b1;
                w_fun = 2'd1; w_flg = 1'b1;
            end
            OP_CMP:  begin
                w_alu = 1'b1; w_same2 = 1'b1; w_op2 = 1'b1;
                w_fun = 2'd3; w_flg = 1'b1;
            end
            OP_J:    w_pcsel = 2'd1;
            OP_JAL:  begin w_pcsel = 2'd1; w_jal = 1'b1; end
            OP_JR:   w_pcsel = 2'd3;
            OP_JNM:  w_pcsel = !flags[3] ? 2'd1 : 2'd2;
            OP_JM:   w_pcsel =  flags[3] ? 2'd1 : 2'd2;
            OP_JV:   w_pcsel =  flags[2] ? 2'd1 : 2'd2;
            OP_JNV:  w_pcsel = !flags[2] ? 2'd1 : 2'd2;
            OP_JC:   w_pcsel =  flags[1] ? 2'd1 : 2'd2;
            OP_JNC:  w_pcsel = !flags[1] ? 2'd1 : 2'd2;
            OP_JZ:   w_pcsel =  flags[0] ? 2'd1 : 2'd2;
            OP_JNZ:  w_pcsel = !flags[0] ? 2'd1 : 2'd2;
            default: begin
`ifdef SEQ_HALT_EN
                w_stop = 1'b1;
`endif
            end
        endcase
    end

    // Phase sequencing, instruction capture and retire counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_irq   <= '0;
            r_cnt   <= '0;
        end else begin
            if (irLoad) r_irq <= IR;
            unique case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (memAck) r_state <= S_DECODE;
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    if (w_lr || w_str) r_state <= S_MEM;
                    else if (w_towb) r_state <= S_WB;
`ifdef SEQ_HALT_EN
                    else if (w_stop) r_state <= S_HALT;
`endif
                    else begin
                        r_state <= S_FETCH;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                S_MEM: begin
                    if (memAck) begin
                        if (w_lr) r_state <= S_WB;
                        else begin
                            r_state <= S_FETCH;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
`ifdef SEQ_HALT_EN
                S_HALT:   r_state <= S_HALT;
`endif
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes for the current phase; everything else stays low
    always_comb begin
        irLoad          = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        addrSel         = 1'b0;
        pcWrite         = 1'b0;
        choosePCUpdate  = 2'd0;
        funSel          = 2'd0;
        chooseOperand2  = 1'b0;
        flagsLoad       = 1'b0;
        regWrite        = 1'b0;
        ldRA            = 1'b0;
        chooseWriteBack = 1'b0;
        rChooseOne      = 3'd0;
        rChooseTwo      = 3'd0;
        writeChoose     = 3'd0;
        halted          = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                irLoad  = memAck;
            end
            S_DECODE: begin
                if (w_alu)   rChooseOne = r_irq[10:8];
                if (w_regop) rChooseTwo = r_irq[7:5];
                if (w_same2) rChooseTwo = r_irq[10:8];
            end
            S_EXEC: begin
                funSel         = w_fun;
                chooseOperand2 = w_op2;
                flagsLoad      = w_flg;
                pcWrite        = !w_stop;
                choosePCUpdate = w_stop ? 2'd0 : w_pcsel;
                ldRA           = w_jal;
            end
            S_MEM: begin
                addrSel    = 1'b1;
                rChooseOne = r_irq[10:8];
                MemRead    = w_lr;
                MemWrite   = w_str;
                if (w_str) rChooseTwo = r_irq[7:5];
            end
            S_WB: begin
                regWrite        = 1'b1;
                writeChoose     = w_lr ? r_irq[7:5] : r_irq[10:8];
                chooseWriteBack = w_lr;
            end
`ifdef SEQ_HALT_EN
            S_HALT:  halted = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Bench for multi_cycle_sequencer: directed instructions checked every cycle
// against an instruction-level model, plus literal pins; honours SEQ_HALT_EN.
module tb_multi_cycle_sequencer;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   IR;
    logic [3:0]    flags;
    logic          memAck;
    logic          irLoad, MemRead, MemWrite, addrSel, pcWrite;
    logic [1:0]    choosePCUpdate, funSel;
    logic          chooseOperand2, flagsLoad, regWrite, ldRA;
    logic          chooseWriteBack, halted;
    logic [2:0]    rChooseOne, rChooseTwo, writeChoose;
    logic [CW-1:0] instrCount;

    multi_cycle_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .IR(IR), .flags(flags),
        .memAck(memAck), .irLoad(irLoad), .MemRead(MemRead),
        .MemWrite(MemWrite), .addrSel(addrSel), .pcWrite(pcWrite),
        .choosePCUpdate(choosePCUpdate), .funSel(funSel),
        .chooseOperand2(chooseOperand2), .flagsLoad(flagsLoad),
        .regWrite(regWrite), .ldRA(ldRA),
        .chooseWriteBack(chooseWriteBack), .rChooseOne(rChooseOne),
        .rChooseTwo(rChooseTwo), .writeChoose(writeChoose),
        .instrCount(instrCount), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic irl, mrd, mwr, asel, pcw;
        logic [1:0] cpu, fun;
        logic op2, flg, rw, ra, wb;
        logic [2:0] r1, r2, wc;
        logic hlt;
    } outs_t;

    typedef struct {
        string nm;
        int    sel;
        int    got;
        int    want;
        int    at;
    } pin_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  fl;
        int          fw;
        int          mw;
        int          cyc;
    } vec_t;

    outs_t         dut_o;
    outs_t         exp_o;
    logic          exp_v = 1'b0;
    logic [CW-1:0] exp_cnt;
    pin_t          pins[128];
    int            pn = 0;
    int            ncyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    assign dut_o = {irLoad, MemRead, MemWrite, addrSel, pcWrite,
                    choosePCUpdate, funSel, chooseOperand2, flagsLoad,
                    regWrite, ldRA, chooseWriteBack, rChooseOne,
                    rChooseTwo, writeChoose, halted};

    function automatic int fld(input int s);
        case (s)
            0:  return int'(funSel);
            1:  return int'(flagsLoad);
            2:  return int'(choosePCUpdate);
            3:  return int'(pcWrite);
            4:  return int'(regWrite);
            5:  return int'(writeChoose);
            6:  return int'(chooseWriteBack);
            7:  return int'(instrCount);
            8:  return int'(MemRead);
            9:  return int'(addrSel);
            10: return int'(halted);
            11: return int'(MemWrite);
            12: return int'(irLoad);
            default: return int'(ldRA);
        endcase
    endfunction

    // Single checker: full output vector each cycle, plus scheduled pins
    always @(negedge clk) begin
        int g;
        if (exp_v) begin
            n_cmp++;
            if (dut_o !== exp_o || instrCount !== exp_cnt) begin
                n_bad++;
                $display("FAIL cycle%0d outs got=%h cnt=%0d want=%h cnt=%0d",
                         ncyc, dut_o, instrCount, exp_o, exp_cnt);
            end
        end
        for (int k = 0; k < pn; k++) begin
            if (pins[k].at == ncyc) begin
                g = (pins[k].sel < 0) ? pins[k].got : fld(pins[k].sel);
                n_cmp++;
                if (g != pins[k].want) begin
                    n_bad++;
                    $display("FAIL %s got=%0d want=%0d",
                             pins[k].nm, g, pins[k].want);
                end
            end
        end
        ncyc++;
    end

    // ---- instruction-level model ----
    function automatic string mn(input logic [4:0] op);
        case (op)
            5'b00000: return "li";
            5'b00001: return "lr";
            5'b00010: return "str";
            5'b01000: return "addi";
            5'b01001: return "subi";
            5'b01010: return "mnsi";
            5'b01100: return "addr";
            5'b01101: return "subr";
            5'b01110: return "mnsr";
            5'b01111: return "cmp";
            5'b11111: return "j";
            5'b10000: return "jnm";
            5'b10001: return "jz";
            5'b10010: return "jnz";
            5'b10011: return "jc";
            5'b10100: return "jnc";
            5'b10101: return "jv";
            5'b10110: return "jnv";
            5'b10111: return "jm";
            5'b11011: return "jal";
            5'b11101: return "jr";
            default:  return "undef";
        endcase
    endfunction

    function automatic bit is_alu(input string m);
        case (m)
            "li", "addi", "subi", "mnsi", "addr", "subr", "mnsr", "cmp":
                return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit writes(input string m);
        case (m)
            "li", "addi", "subi", "addr", "subr", "lr": return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit stops(input string m);
`ifdef SEQ_HALT_EN
        return m == "undef";
`else
        return (m == "undef") && 1'b0;
`endif
    endfunction

    function automatic int cond(input string m, input logic [3:0] f);
        // -1: not a conditional jump; else 1 taken, 0 not taken
        case (m)
            "jnm": return int'(!f[3]);
            "jm":  return int'(f[3]);
            "jv":  return int'(f[2]);
            "jnv": return int'(!f[2]);
            "jc":  return int'(f[1]);
            "jnc": return int'(!f[1]);
            "jz":  return int'(f[0]);
            "jnz": return int'(!f[0]);
            default: return -1;
        endcase
    endfunction

    function automatic outs_t exp_fetch(input bit last);
        outs_t e = '0;
        e.mrd = 1'b1;
        e.irl = last;
        return e;
    endfunction

    function automatic outs_t exp_decode(input logic [15:0] ir);
        outs_t e = '0;
        string m = mn(ir[15:11]);
        if (is_alu(m)) e.r1 = ir[10:8];
        if (m == "addr" || m == "subr" || m == "mnsr" || m == "str")
            e.r2 = ir[7:5];
        if (m == "cmp" || m == "lr") e.r2 = ir[10:8];
        return e;
    endfunction

    function automatic outs_t exp_exec(input logic [15:0] ir,
                                       input logic [3:0] f);
        outs_t e = '0;
        string m = mn(ir[15:11]);
        int c = cond(m, f);
        if (stops(m)) return e;
        e.pcw = 1'b1;
        case (m)
            "subi", "subr", "mnsi", "mnsr": e.fun = 2'd1;
            "li":  e.fun = 2'd2;
            "cmp": e.fun = 2'd3;
            default: e.fun = 2'd0;
        endcase
        e.op2 = (m == "addr" || m == "subr" || m == "mnsr" || m == "cmp");
        e.flg = is_alu(m) && (m != "li");
        if (m == "j") e.cpu = 2'd1;
        else if (m == "jal") begin e.cpu = 2'd1; e.ra = 1'b1; end
        else if (m == "jr") e.cpu = 2'd3;
        else if (c >= 0) e.cpu = (c == 1) ? 2'd1 : 2'd2;
        else e.cpu = 2'd2;
        return e;
    endfunction

    function automatic outs_t exp_mem(input logic [15:0] ir);
        outs_t e = '0;
        string m = mn(ir[15:11]);
        e.asel = 1'b1;
        e.r1 = ir[10:8];
        if (m == "lr") e.mrd = 1'b1;
        if (m == "str") begin e.mwr = 1'b1; e.r2 = ir[7:5]; end
        return e;
    endfunction

    function automatic outs_t exp_wb(input logic [15:0] ir);
        outs_t e = '0;
        bit lr = (mn(ir[15:11]) == "lr");
        e.rw = 1'b1;
        e.wc = lr ? ir[7:5] : ir[10:8];
        e.wb = lr;
        return e;
    endfunction

    // ---- driver ----
    task automatic pin(input string nm, input int sel, input int want,
                       input int dly, input int got = 0);
        if (pn < 128) begin
            pins[pn] = '{nm, sel, got, want, ncyc + dly};
            pn++;
        end
    endtask

    task automatic cyc(input outs_t e, input logic ack);
        memAck = ack;
        exp_o  = e;
        exp_v  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] ir, input logic [3:0] fl,
                       input int fw, input int mw, input int want);
        string m = mn(ir[15:11]);
        int n = 0;
        flags = ~fl;
        for (int i = 0; i <= fw; i++) begin
            IR = (i == fw) ? ir : ~ir;
            cyc(exp_fetch(i == fw), i == fw);
            n++;
        end
        IR = 16'hFFFF;
        cyc(exp_decode(ir), 1'b1);
        n++;
        flags = fl;
        cyc(exp_exec(ir, fl), 1'b1);
        n++;
        flags = ~fl;
        if (m == "lr" || m == "str") begin
            for (int i = 0; i <= mw; i++) begin
                cyc(exp_mem(ir), i == mw);
                n++;
            end
        end
        if (writes(m)) begin
            cyc(exp_wb(ir), 1'b1);
            n++;
        end
        pin({"cycles_", m}, -1, want, 0, n);
        if (!stops(m)) exp_cnt = exp_cnt + 1'b1;
    endtask

    vec_t tv[18] = '{
        '{16'h0500, 4'h0, 0, 0, 4},
        '{16'h4B00, 4'h0, 0, 0, 4},
        '{16'h6140, 4'h0, 0, 0, 4},
        '{16'h6EA0, 4'h0, 0, 0, 4},
        '{16'h7240, 4'h0, 0, 0, 3},
        '{16'h7C20, 4'h0, 0, 0, 3},
        '{16'h1360, 4'h0, 0, 0, 4},
        '{16'h1360, 4'h0, 1, 1, 6},
        '{16'hF800, 4'h0, 0, 0, 3},
        '{16'hD800, 4'h0, 0, 0, 3},
        '{16'hE800, 4'h0, 0, 0, 3},
        '{16'h8000, 4'h8, 0, 0, 3},
        '{16'hB800, 4'h8, 0, 0, 3},
        '{16'h9800, 4'h2, 0, 0, 3},
        '{16'hA000, 4'h2, 0, 0, 3},
        '{16'hA800, 4'h4, 0, 0, 3},
        '{16'hB000, 4'h0, 0, 0, 3},
        '{16'h9000, 4'h1, 0, 0, 3}
    };

    initial begin
        outs_t h;
        rst_n   = 1'b0;
        memAck  = 1'b1;
        IR      = 16'hFFFF;
        flags   = 4'hF;
        exp_cnt = '0;
        pin("rst_cnt", 7, 0, 0);
        pin("rst_pcwrite", 3, 0, 0);
        cyc('0, 1'b1);
        cyc('0, 1'b1);
        rst_n = 1'b1;
        cyc('0, 1'b1);

        // addi r1, memory always ready
        pin("addi_fun", 0, 0, 2);
        pin("addi_flagsload", 1, 1, 2);
        pin("addi_pcwrite", 3, 1, 2);
        pin("addi_pcsel", 2, 2, 2);
        pin("addi_regwrite", 4, 1, 3);
        pin("addi_wc", 5, 1, 3);
        pin("addi_count", 7, 1, 4);
        run(16'h4105, 4'h0, 0, 0, 4);

        // three fetch wait states
        for (int i = 0; i < 4; i++) begin
            pin("fw_memread", 8, 1, i);
            pin("fw_irload", 12, (i == 3) ? 1 : 0, i);
        end
        run(16'h5200, 4'h0, 3, 0, 6);

        pin("jz_taken", 2, 1, 2);
        run(16'h8800, 4'h1, 0, 0, 3);
        pin("jz_not_taken", 2, 2, 2);
        run(16'h8800, 4'h0, 0, 0, 3);

        // lr with two memory wait states
        for (int i = 3; i < 6; i++) begin
            pin("lr_memread", 8, 1, i);
            pin("lr_addrsel", 9, 1, i);
        end
        pin("lr_wbsel", 6, 1, 6);
        pin("lr_wc", 5, 2, 6);
        run(16'h0A40, 4'h0, 0, 2, 7);

        foreach (tv[k]) run(tv[k].ir, tv[k].fl, tv[k].fw, tv[k].mw, tv[k].cyc);

        // reset pulled during the MEM phase of a store
        flags = 4'h0;
        IR = 16'h1360;
        cyc(exp_fetch(1'b1), 1'b1);
        IR = 16'hFFFF;
        cyc(exp_decode(16'h1360), 1'b1);
        cyc(exp_exec(16'h1360, 4'h0), 1'b1);
        pin("str_memwrite", 11, 1, 0);
        cyc(exp_mem(16'h1360), 1'b0);
        rst_n = 1'b0;
        exp_cnt = '0;
        pin("rst_memwrite", 11, 0, 0);
        cyc('0, 1'b0);
        cyc('0, 1'b1);
        rst_n = 1'b1;
        cyc('0, 1'b1);

        // undefined opcode
`ifdef SEQ_HALT_EN
        pin("undef_pcwrite", 3, 0, 2);
        run(16'h3000, 4'h0, 0, 0, 3);
        h = '0;
        h.hlt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pin("halt_flag", 10, 1, 0);
            pin("halt_pcwrite", 3, 0, 0);
            pin("halt_count", 7, 0, 0);
            cyc(h, 1'b1);
        end
`else
        pin("undef_pcwrite", 3, 1, 2);
        pin("undef_pcsel", 2, 2, 2);
        pin("undef_halted", 10, 0, 2);
        run(16'h3000, 4'h0, 0, 0, 3);
        pin("after_undef_count", 7, 1, 0);
        run(16'h4105, 4'h0, 0, 0, 4);
`endif

        exp_v = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_cycle_sequencer.md
# multi_cycle_sequencer

Multi-cycle control sequencer for the 16-bit CPU datapath. It steps every instruction through FETCH, DECODE, EXEC, MEM and WB states using the same 5-bit opcode set as the single-cycle decoder, and drives the existing PC, register-file, ALU and memory select lines one phase at a time. Memory accesses use a req/ack handshake with arbitrary wait states. A retired-instruction counter is also provided.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter
Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- IR  in  16  memory read data, captured as the instruction in FETCH
- flags  in  4  {M,V,C,Z} = flags[3:0], from the flags register
- memAck  in  1  memory completes the current request this cycle
- irLoad  out  1  latch IR into the instruction register
- MemRead, MemWrite  out  1 each  memory request, held until memAck
- addrSel  out  1  0 = PC drives the address, 1 = register rChooseOne drives it
- pcWrite  out  1  update PC this cycle
- choosePCUpdate  out  2  0 hold, 1 jump target, 2 PC+1, 3 RA (jr)
- funSel  out  2  ALU op: 0 add, 1 sub, 2 pass, 3 compare
- chooseOperand2  out  1  0 immediate, 1 register
- flagsLoad  out  1  write ALU flags
- regWrite, ldRA  out  1 each  register-file write, RA link write
- chooseWriteBack  out  1  0 ALU result, 1 memory data
- rChooseOne, rChooseTwo, writeChoose  out  3 each  register selects
- instrCount  out  CNT_W  retired instructions
- halted  out  1  sequencer stopped (macro only, else tied 0)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- An internal instruction register (`irq`) is loaded when irLoad is high. All outputs are decoded from the state and `irq`, and are 0 in every state or case not listed below.
- IDLE: entered from reset. Goes to FETCH on the next edge.
- FETCH: MemRead=1, addrSel=0. While memAck=0, stay in FETCH. When memAck=1: irLoad=1, go to DECODE.
- DECODE: register selects are driven.
  - ALU-type (li, addi, subi, mnsi, addr, subr, mnsr, cmp): rChooseOne=irq[10:8].
  - Register-operand ops (addr, subr, mnsr, str): rChooseTwo=irq[7:5].
  - cmp and lr: rChooseTwo=irq[10:8].
  - Go to EXEC.
- EXEC:
  - ALU ops: funSel as decoded (add 0, sub/mns 1, li 2, cmp 3), chooseOperand2 per opcode.
  - flagsLoad=1 for addi, subi, mnsi, addr, subr, mnsr, cmp.
  - Every instruction asserts pcWrite=1. choosePCUpdate=2, except:
    - j: 1
    - jal: 1, with ldRA=1
    - jr: 3
    - conditional jumps: 1 if the condition holds on the flags sampled this cycle, else 2.
  - Next state:
    - lr/str → MEM
    - li, addi, subi, addr, subr → WB
    - all others → FETCH
- MEM: addrSel=1, rChooseOne=irq[10:8].
  - lr: MemRead=1.
  - str: MemWrite=1, rChooseTwo=irq[7:5].
  - Held until memAck. Then lr → WB, str → FETCH.
- WB: regWrite=1.
  - writeChoose = irq[10:8], except lr uses irq[7:5].
  - chooseWriteBack=1 only for lr.
  - Go to FETCH.
- Opcodes: li 00000, lr 00001, str 00010, addi 01000, subi 01001, mnsi 01010, addr 01100, subr 01101, mnsr 01110, cmp 01111, j 11111, jnm 10000, jz 10001, jnz 10010, jc 10011, jnc 10100, jv 10101, jnv 10110, jm 10111, jal 11011, jr 11101.
- Undefined opcode: treated as a NOP (PC+1 in EXEC, then FETCH).
- instrCount increments by 1 on each transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE, `irq`=0, instrCount=0, every output 0.
- Reset asserted mid-instruction: the instruction is abandoned. No further strobes are issued.
- memAck is sampled on the rising clock edge. memAck already high in the first request cycle gives a zero-wait access.
- memAck outside FETCH/MEM is ignored.
- Minimum cycles per instruction, with zero-wait memory:
  - branches, mnsi, mnsr, cmp, NOP: 3
  - li, addi, subi, addr, subr: 4
  - str: 4
  - lr: 5
- Each memory wait cycle adds one cycle.
- The flags input is sampled only in EXEC. A flag update from instruction N is therefore visible to a branch at N+1.

## Configuration
- SEQ_HALT_EN defined:
  - An undefined opcode in EXEC goes to HALT with pcWrite=0.
  - HALT holds halted=1, all strobes 0, and a frozen instrCount until reset.
- SEQ_HALT_EN undefined: undefined opcodes are NOPs, the HALT state is absent, and halted is tied to 0.

## Test plan
- Reset, then memAck tied 1, IR=0x4105 (addi r1): states IDLE→FETCH→DECODE→EXEC→WB. In EXEC: funSel=0, flagsLoad=1, pcWrite=1, choosePCUpdate=2. In WB: regWrite=1, writeChoose=1. instrCount=1.
- Fetch with memAck held low for 3 cycles: MemRead stays 1 for 4 cycles and irLoad pulses only once.
- IR=0x8800 (jz): flags=0001 in EXEC gives choosePCUpdate=1. flags=0000 gives 2. Both take 3 cycles.
- IR=0x0A40 (lr r2→r2? src r2, dst r2) with 2 memory wait cycles in MEM: MEM lasts 3 cycles with addrSel=1 and MemRead=1. Then WB with chooseWriteBack=1.
- Pull rst_n low during MEM of a str: MemWrite drops immediately and the next cycle after release is IDLE.
- IR=0x3000 (undefined opcode):
  - With SEQ_HALT_EN: halted=1 and no further pcWrite.
  - Without SEQ_HALT_EN: PC+1 and fetching continues.
